// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between fetch_unit (master) and the memory (slave).
interface fetch_unit_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic              mem_rvalid;

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_rdata,
      input  mem_rvalid
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_rdata,
      output mem_rvalid
   );
endinterface

// File: rtl/fetch_unit.sv
// Program counter, instruction-memory fetch with request/valid handshake and timeout,
// and instruction register feeding the decoder.
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       TIMEOUT  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic              ir_en,
   input  logic              pc_en,
   input  logic              pc_disp_en,
   input  logic [7:0]        disp8,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_addr,
   fetch_unit_if.master      mem,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       instr,
   output logic              fetch_done,
   output logic              fetch_busy,
   output logic              fetch_err
);

   localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam int unsigned EXT_W   = ADDR_W - 8;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_WAIT = 2'd1,
      F_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [15:0]       buffer;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] disp_ext;

   assign disp_ext = {{EXT_W{disp8[7]}}, disp8};

   // PC update: jump beats branch beats increment; wraps modulo 2^ADDR_W
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else if (pc_load) begin
         pc <= pc_load_addr;
      end else if (pc_disp_en) begin
         pc <= pc + disp_ext;
      end else if (pc_en) begin
         pc <= pc + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr <= 16'h0000;
      end else if (ir_en) begin
         instr <= buffer;
      end
   end

   // Fetch FSM; the count holds the number of F_WAIT edges already spent without data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= F_IDLE;
         mem.mem_rd   <= 1'b0;
         mem.mem_addr <= '0;
         buffer       <= 16'h0000;
         cnt          <= '0;
         fetch_done   <= 1'b0;
         fetch_busy   <= 1'b0;
         fetch_err    <= 1'b0;
      end else begin
         case (state)
            F_IDLE, F_DONE: begin
               if (fetch_req) begin
                  state        <= F_WAIT;
                  mem.mem_rd   <= 1'b1;
                  mem.mem_addr <= pc;
                  cnt          <= '0;
                  fetch_done   <= 1'b0;
                  fetch_busy   <= 1'b1;
                  fetch_err    <= 1'b0;
               end
            end
            F_WAIT: begin
               if (mem.mem_rvalid) begin
                  state      <= F_DONE;
                  mem.mem_rd <= 1'b0;
                  buffer     <= mem.mem_rdata;
                  fetch_done <= 1'b1;
                  fetch_busy <= 1'b0;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state      <= F_DONE;
                  mem.mem_rd <= 1'b0;
                  buffer     <= 16'h0000;
                  fetch_done <= 1'b1;
                  fetch_busy <= 1'b0;
                  fetch_err  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state      <= F_IDLE;
               mem.mem_rd <= 1'b0;
               fetch_done <= 1'b0;
               fetch_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of PC, fetch and IR.
module tb_fetch_unit;

   localparam int unsigned ADDR_W   = 16;
   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam int          TIMEOUT  = 8;

   logic        clk;
   logic        reset;
   logic        fetch_req;
   logic        ir_en;
   logic        pc_en;
   logic        pc_disp_en;
   logic [7:0]  disp8;
   logic        pc_load;
   logic [15:0] pc_load_addr;
   logic [15:0] pc;
   logic [15:0] instr;
   logic        fetch_done;
   logic        fetch_busy;
   logic        fetch_err;

   fetch_unit_if #(.ADDR_W(ADDR_W)) mem ();

   fetch_unit #(
      .ADDR_W  (ADDR_W),
      .RESET_PC(RESET_PC),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .ir_en       (ir_en),
      .pc_en       (pc_en),
      .pc_disp_en  (pc_disp_en),
      .disp8       (disp8),
      .pc_load     (pc_load),
      .pc_load_addr(pc_load_addr),
      .mem         (mem),
      .pc          (pc),
      .instr       (instr),
      .fetch_done  (fetch_done),
      .fetch_busy  (fetch_busy),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one outstanding fetch transaction plus architectural registers
   int          m_pc;
   logic [15:0] m_instr;
   logic [15:0] m_buf;
   logic [15:0] m_addr;
   bit          m_pending;
   int          m_waited;
   bit          m_done;
   bit          m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sext8(input logic [7:0] d);
      return (d >= 8'h80) ? int'(d) - 256 : int'(d);
   endfunction

   task automatic model_reset();
      m_pc      = int'(RESET_PC);
      m_instr   = 16'h0000;
      m_buf     = 16'h0000;
      m_addr    = 16'h0000;
      m_pending = 0;
      m_waited  = 0;
      m_done    = 0;
      m_err     = 0;
   endtask

   // One clock edge worth of behaviour, using the inputs as they stand at the edge
   task automatic model_edge();
      int          old_pc;
      logic [15:0] old_buf;
      old_pc  = m_pc;
      old_buf = m_buf;
      if (pc_load)         m_pc = int'(pc_load_addr);
      else if (pc_disp_en) m_pc = (m_pc + sext8(disp8) + 65536) % 65536;
      else if (pc_en)      m_pc = (m_pc + 1) % 65536;
      if (ir_en) m_instr = old_buf;
      if (m_pending) begin
         if (mem.mem_rvalid) begin
            m_buf     = mem.mem_rdata;
            m_pending = 0;
            m_done    = 1;
         end else begin
            m_waited++;
            if (m_waited >= TIMEOUT) begin
               m_buf     = 16'h0000;
               m_pending = 0;
               m_done    = 1;
               m_err     = 1;
            end
         end
      end else if (fetch_req) begin
         m_addr    = 16'(old_pc);
         m_pending = 1;
         m_waited  = 0;
         m_done    = 0;
         m_err     = 0;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".pc"},         32'(pc),          32'(m_pc));
      check({tag, ".instr"},      32'(instr),       32'(m_instr));
      check({tag, ".mem_rd"},     32'(mem.mem_rd),  32'(m_pending));
      check({tag, ".fetch_busy"}, 32'(fetch_busy),  32'(m_pending));
      check({tag, ".fetch_done"}, 32'(fetch_done),  32'(m_done));
      check({tag, ".fetch_err"},  32'(fetch_err),   32'(m_err));
      if (m_pending) check({tag, ".mem_addr"}, 32'(mem.mem_addr), 32'(m_addr));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic quiet();
      fetch_req      = 0;
      ir_en          = 0;
      pc_en          = 0;
      pc_disp_en     = 0;
      disp8          = 8'h00;
      pc_load        = 0;
      pc_load_addr   = 16'h0000;
      mem.mem_rvalid = 0;
      mem.mem_rdata  = 16'h0000;
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic pulse_reset(input string tag);
      #2 reset = 1'b0;
      #1;
      model_reset();
      compare_all(tag);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic load_pc(input logic [15:0] a);
      quiet();
      pc_load = 1; pc_load_addr = a;
      step("load");
      quiet();
   endtask

   initial begin
      quiet();
      reset = 1'b0;
      model_reset();
      #12;
      compare_all("reset");
      check("reset.mem_addr", 32'(mem.mem_addr), 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Basic fetch with two-cycle latency, then latch into IR
      fetch_req = 1;
      step("t1.req");
      check("t1.addr0", 32'(mem.mem_addr), 32'h0000);
      check("t1.rd_c1", 32'(mem.mem_rd), 32'h1);
      fetch_req = 0;
      step("t1.w1");
      check("t1.rd_c2", 32'(mem.mem_rd), 32'h1);
      mem.mem_rvalid = 1; mem.mem_rdata = 16'h5123;
      step("t1.rv");
      check("t1.rd_drop", 32'(mem.mem_rd), 32'h0);
      check("t1.done", 32'(fetch_done), 32'h1);
      quiet(); ir_en = 1;
      step("t1.ir");
      check("t1.instr", 32'(instr), 32'h5123);
      quiet();

      // PC arithmetic, priority and wrap
      load_pc(16'h0010);
      pc_en = 1; step("t2.inc");
      check("t2.inc", 32'(pc), 32'h0011);
      quiet(); pc_disp_en = 1; disp8 = 8'hFE; step("t2.disp");
      check("t2.disp", 32'(pc), 32'h000F);
      quiet(); pc_load = 1; pc_en = 1; pc_disp_en = 1; disp8 = 8'h05; pc_load_addr = 16'h1234;
      step("t2.prio");
      check("t2.prio", 32'(pc), 32'h1234);
      load_pc(16'hFFFF);
      pc_en = 1; step("t3.wrap");
      check("t3.wrap", 32'(pc), 32'h0000);
      quiet(); pc_disp_en = 1; disp8 = 8'h80; step("t3.neg");
      check("t3.neg", 32'(pc), 32'hFF80);
      quiet();

      // Timeout: no data for TIMEOUT cycles
      fetch_req = 1; step("t4.req");
      quiet();
      for (int i = 1; i < TIMEOUT; i++) step("t4.wait");
      check("t4.rd_last", 32'(mem.mem_rd), 32'h1);
      step("t4.to");
      check("t4.rd_drop", 32'(mem.mem_rd), 32'h0);
      check("t4.err", 32'(fetch_err), 32'h1);
      check("t4.done", 32'(fetch_done), 32'h1);
      ir_en = 1; step("t4.ir");
      check("t4.instr", 32'(instr), 32'h0000);
      quiet(); fetch_req = 1; step("t4.clr");
      check("t4.err_clr", 32'(fetch_err), 32'h0);
      quiet(); mem.mem_rvalid = 1; mem.mem_rdata = 16'hABCD; step("t4.fin");
      quiet();

      // Jump during an in-flight fetch keeps the registered address
      load_pc(16'h0005);
      fetch_req = 1; step("t5.req");
      quiet(); pc_load = 1; pc_load_addr = 16'h0040; step("t5.jmp");
      check("t5.addr_hold", 32'(mem.mem_addr), 32'h0005);
      quiet(); mem.mem_rvalid = 1; mem.mem_rdata = 16'h7E57; step("t5.rv");
      quiet(); ir_en = 1; fetch_req = 1; step("t5.next");
      check("t5.instr", 32'(instr), 32'h7E57);
      check("t5.addr_new", 32'(mem.mem_addr), 32'h0040);
      quiet(); mem.mem_rvalid = 1; mem.mem_rdata = 16'h1111; step("t5.fin");
      quiet();

      // Reset in the middle of a fetch, then a late rvalid
      load_pc(16'h0123);
      fetch_req = 1; step("t6.req");
      quiet();
      pulse_reset("t6.rst");
      check("t6.rd", 32'(mem.mem_rd), 32'h0);
      check("t6.pc", 32'(pc), 32'(RESET_PC));
      mem.mem_rvalid = 1; mem.mem_rdata = 16'hDEAD; step("t6.late");
      quiet(); ir_en = 1; step("t6.ir");
      check("t6.done", 32'(fetch_done), 32'h0);
      check("t6.instr", 32'(instr), 32'h0000);
      quiet();

      // Randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         fetch_req      = ($urandom_range(0, 99) < 30);
         ir_en          = ($urandom_range(0, 99) < 25);
         pc_en          = ($urandom_range(0, 99) < 20);
         pc_disp_en     = ($urandom_range(0, 99) < 10);
         disp8          = 8'($urandom);
         pc_load        = ($urandom_range(0, 99) < 5);
         pc_load_addr   = 16'($urandom);
         mem.mem_rdata  = 16'($urandom);
         mem.mem_rvalid = m_pending ? ($urandom_range(0, 99) < 30)
                                    : ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 599) == 0) begin
            pulse_reset("rand.rst");
         end else begin
            step("rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
